// File: rtl/bridge_controller.sv
// bridge_controller
//
// Drawbridge sequencing controller. Sits downstream of the deck car counter.
// Stops road traffic, waits for an empty deck, raises the deck, serves the boat,
// then lowers the deck and reopens the road. The deck is never lifted while
// road traffic may still be entering or while cars remain on it.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset
//   ExistCar   in   high while cars are on the deck
//   BoatReq    in   level, a boat is waiting
//   UpLimit    in   deck fully up (already synchronized)
//   DownLimit  in   deck fully down (already synchronized)
//   FaultClear in   operator fault acknowledge
//   CarLight   out  2'b00 red, 2'b01 yellow, 2'b10 green
//   BoatLight  out  1 = boat green
//   MotorUp    out  lift motor raise
//   MotorDown  out  lift motor lower
//   Fault      out  controller is in FAULT
//   State      out  debug state code (ROAD 0 .. FAULT 6)
//
// Optional feature macro: BRIDGE_FAULT_EN
//   Defined   : motor timeout, both-limits detection and a latched FAULT state.
//   Undefined : RAISE/LOWER wait indefinitely, Fault is constant 0,
//               FaultClear is ignored.
//
// All outputs except State are registered and decoded from the next state,
// so they change on the same edge as the state register.

module bridge_controller #(
    parameter int unsigned MIN_ROAD      = 32,
    parameter int unsigned YELLOW        = 8,
    parameter int unsigned CLEAR         = 4,
    parameter int unsigned BOAT_GREEN    = 64,
    parameter int unsigned MOTOR_TIMEOUT = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ExistCar,
    input  logic       BoatReq,
    input  logic       UpLimit,
    input  logic       DownLimit,
    input  logic       FaultClear,
    output logic [1:0] CarLight,
    output logic       BoatLight,
    output logic       MotorUp,
    output logic       MotorDown,
    output logic       Fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        StRoad   = 3'd0,
        StYellow = 3'd1,
        StClear  = 3'd2,
        StRaise  = 3'd3,
        StBoat   = 3'd4,
        StLower  = 3'd5,
        StFault  = 3'd6
    } stateT;

    localparam logic [15:0] MinRoadC   = 16'(MIN_ROAD);
    localparam logic [15:0] YellowLast = 16'(YELLOW - 1);
    localparam logic [15:0] ClearLast  = 16'(CLEAR - 1);
    localparam logic [15:0] BoatLast   = 16'(BOAT_GREEN - 1);
    localparam logic [15:0] TimerMax   = 16'hFFFF;

`ifdef BRIDGE_FAULT_EN
    localparam logic [15:0] MotorLast  = 16'(MOTOR_TIMEOUT - 1);
`else
    // Keeps the fault-only inputs and parameter referenced in the default build.
    logic unusedFaultInputs;
    assign unusedFaultInputs = FaultClear ^ (MOTOR_TIMEOUT == 0);
`endif

    stateT       stateQ, stateD;
    logic [15:0] timerQ, timerD;

    logic [1:0]  carLightD;
    logic        boatLightD;
    logic        motorUpD;
    logic        motorDownD;
    logic        faultD;

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StRoad: begin
                if (BoatReq && (timerQ == MinRoadC)) stateD = StYellow;
            end
            StYellow: begin
                if (timerQ == YellowLast) stateD = StClear;
            end
            StClear: begin
                // Timer holds the length of the current run of empty-deck cycles.
                if (!ExistCar && (timerQ == ClearLast)) stateD = StRaise;
            end
            StRaise: begin
                if (UpLimit) stateD = StBoat;
`ifdef BRIDGE_FAULT_EN
                else if (timerQ == MotorLast) stateD = StFault;
`endif
            end
            StBoat: begin
                if (timerQ == BoatLast) stateD = StLower;
            end
            StLower: begin
                if (DownLimit) stateD = StRoad;
`ifdef BRIDGE_FAULT_EN
                else if (timerQ == MotorLast) stateD = StFault;
`endif
            end
            StFault: begin
`ifdef BRIDGE_FAULT_EN
                if (FaultClear && DownLimit && !UpLimit) stateD = StRoad;
`else
                stateD = StLower;
`endif
            end
            default: stateD = StLower;
        endcase
`ifdef BRIDGE_FAULT_EN
        // Contradictory limit switches override every other decision.
        if (UpLimit && DownLimit) stateD = StFault;
`endif
    end

    // Shared timer: cleared on every state change, saturating otherwise.
    always_comb begin
        timerD = timerQ;
        if (stateD != stateQ) begin
            timerD = '0;
        end else if ((stateQ == StClear) && ExistCar) begin
            timerD = '0;
        end else if (stateQ == StRoad) begin
            if (timerQ != MinRoadC) timerD = timerQ + 16'd1;
        end else if (timerQ != TimerMax) begin
            timerD = timerQ + 16'd1;
        end
    end

    // Output decode from the next state.
    always_comb begin
        carLightD  = 2'b00;
        boatLightD = 1'b0;
        motorUpD   = 1'b0;
        motorDownD = 1'b0;
        faultD     = 1'b0;
        case (stateD)
            StRoad:   carLightD  = 2'b10;
            StYellow: carLightD  = 2'b01;
            StRaise:  motorUpD   = 1'b1;
            StBoat:   boatLightD = 1'b1;
            StLower:  motorDownD = 1'b1;
`ifdef BRIDGE_FAULT_EN
            StFault:  faultD     = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset parks the FSM in LOWER with every actuator off; the first edge
    // afterwards starts lowering (or opens the road if already down).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateQ    <= StLower;
            timerQ    <= '0;
            CarLight  <= 2'b00;
            BoatLight <= 1'b0;
            MotorUp   <= 1'b0;
            MotorDown <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            timerQ    <= timerD;
            CarLight  <= carLightD;
            BoatLight <= boatLightD;
            MotorUp   <= motorUpD;
            MotorDown <= motorDownD;
            Fault     <= faultD;
        end
    end

    assign State = stateQ;

endmodule
